multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Opcode  in  6  instruction bits [31:26] from the IR.
- Func  in  6  instruction bits [5:0] from the IR.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory access complete this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA  out  1 each  datapath enables and 2:1 mux selects.
- RegDst  out  2  3:1 select: 00 rt, 01 rd, 10 reg 31.
- MemtoReg  out  2  3:1 select: 00 ALUOut, 01 MDR, 10 PC.
- ALUSrcB  out  2  4:1 select: 00 B, 01 const 4, 10 SignExt, 11 SignExt<<2.
- PCSrc  out  2  4:1 select: 00 ALU result, 01 ALUOut, 10 jump target, 11 reg A.
- ALUCtrl  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- State  out  4  current state encoding (debug).
- Done  out  1  one-cycle pulse on last cycle of each instruction.
- Illegal  out  1  one-cycle pulse when an undecoded Opcode/Func is detected in DECODE.
REQ-002 SHALL use one clock and an asynchronous, active-low reset (already decided).

Function
REQ-003 SHALL implement a Moore FSM with these encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, LW_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, I_EXEC=9, I_WB=10, JUMP=11, JAL=12, JR=13.
REQ-004 SHALL default every 1-bit output to 0, every select to 00, and ALUCtrl to add in any state not listed below.
REQ-005 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, PCSrc=00; IRWrite and PCWrite SHALL equal MemReady; FETCH SHALL hold until MemReady=1, then go to DECODE.
REQ-006 DECODE: ALUSrcA=0, ALUSrcB=11, add. Next state by Opcode:
- 000000 R-type: Func=001000 -> JR; otherwise -> R_EXEC.
- 100011 lw, 101011 sw -> MEM_ADDR.
- 000100 -> BRANCH.
- 001000 addi, 001010 slti -> I_EXEC.
- 000010 -> JUMP.
- 000011 -> JAL.
REQ-007 An unlisted Opcode, or an R-type Func outside {100000,100010,100100,100101,101010,001000}, SHALL pulse Illegal and return to FETCH without any register, PC or memory write.
REQ-008 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, add; go to MEM_RD for lw, MEM_WR for sw.
REQ-009 MEM_RD: MemRead=1, IorD=1; hold until MemReady=1, then LW_WB.
REQ-010 LW_WB: RegWrite=1, RegDst=00, MemtoReg=01; Done=1.
REQ-011 MEM_WR: MemWrite=1, IorD=1; hold until MemReady; Done=MemReady.
REQ-012 R_EXEC: ALUSrcA=1, ALUSrcB=00; ALUCtrl from Func: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
REQ-013 R_WB: RegWrite=1, RegDst=01, MemtoReg=00; Done=1.
REQ-014 BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCWriteCond=1, PCSrc=01; Done=1.
REQ-015 I_EXEC: ALUSrcA=1, ALUSrcB=10; ALUCtrl=add for addi, slt for slti.
REQ-016 I_WB: RegWrite=1, RegDst=00, MemtoReg=00; Done=1.
REQ-017 JUMP: PCWrite=1, PCSrc=10; Done=1.
REQ-018 JAL: PCWrite=1, PCSrc=10, RegWrite=1, RegDst=10, MemtoReg=10; Done=1.
REQ-019 JR: PCWrite=1, PCSrc=11; Done=1.
REQ-020 Every state that asserts Done SHALL return to FETCH on the next edge.
REQ-021 The Opcode/Func used in states after DECODE SHALL be those present in that state (the IR is stable because IRWrite=0 outside FETCH).
REQ-022 MemWrite, RegWrite, PCWrite and IRWrite SHALL never be asserted in the same cycle as Illegal.
REQ-023 Branch-taken qualification (PCWriteCond & Zero) is performed in the datapath, not in this block.

Reset
REQ-024 While rst_n=0: State=FETCH, and PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite, Done and Illegal SHALL be 0 regardless of MemReady.
REQ-025 Reset SHALL take effect immediately, including mid-instruction or while waiting on MemReady; after release, execution SHALL restart at FETCH on the first rising edge.

Verification
REQ-026 Bench SHALL cover these directed scenarios:
- add (Op 000000, Func 100000), MemReady=1 throughout -> states 0,1,6,7; R_WB: RegWrite=1, RegDst=01, ALUCtrl was 000 in R_EXEC; Done in cycle 4.
- lw with MemReady low 3 cycles in MEM_RD -> states 0,1,2,3,3,3,3,4; RegWrite only in LW_WB, MemtoReg=01.
- beq -> states 0,1,8; BRANCH: ALUCtrl=001, PCWriteCond=1, PCSrc=01, Done=1.
- jal -> JAL: PCWrite=1, PCSrc=10, RegDst=10, MemtoReg=10, RegWrite=1.
- Opcode 111111 -> Illegal pulse in DECODE, next State=0, no write enables asserted.
- rst_n low during MEM_WR wait -> State=0 and MemWrite=0 immediately (asynchronously); after release, FETCH then DECODE.

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS-subset control FSM
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic [5:0] Func,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUCtrl,
    output logic [3:0] State,
    output logic       Done,
    output logic       Illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_LW_WB    = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_I_EXEC   = 4'd9,
        S_I_WB     = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_JR  = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    state_t     state;
    state_t     decode_next;
    logic       illegal_op;
    logic       func_ok;
    logic [2:0] func_alu;

    // Branch qualification with Zero lives in the datapath.
    logic unused_zero;
    assign unused_zero = Zero;

    always_comb begin
        func_ok  = 1'b1;
        func_alu = ALU_ADD;
        case (Func)
            F_ADD:   func_alu = ALU_ADD;
            F_SUB:   func_alu = ALU_SUB;
            F_AND:   func_alu = ALU_AND;
            F_OR:    func_alu = ALU_OR;
            F_SLT:   func_alu = ALU_SLT;
            default: func_ok  = 1'b0;
        endcase
    end

    always_comb begin
        decode_next = S_FETCH;
        illegal_op  = 1'b0;
        case (Opcode)
            OP_RTYPE: begin
                if (Func == F_JR)
                    decode_next = S_JR;
                else if (func_ok)
                    decode_next = S_R_EXEC;
                else
                    illegal_op = 1'b1;
            end
            OP_LW, OP_SW:     decode_next = S_MEM_ADDR;
            OP_BEQ:           decode_next = S_BRANCH;
            OP_ADDI, OP_SLTI: decode_next = S_I_EXEC;
            OP_J:             decode_next = S_JUMP;
            OP_JAL:           decode_next = S_JAL;
            default:          illegal_op  = 1'b1;
        endcase
    end

    // Single-cycle completion states and unused encodings fall back to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (MemReady) state <= S_DECODE;
                S_DECODE:   state <= decode_next;
                S_MEM_ADDR: state <= (Opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   if (MemReady) state <= S_LW_WB;
                S_MEM_WR:   if (MemReady) state <= S_FETCH;
                S_R_EXEC:   state <= S_R_WB;
                S_I_EXEC:   state <= S_I_WB;
                default:    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ALUSrcB     = 2'b00;
        PCSrc       = 2'b00;
        ALUCtrl     = ALU_ADD;
        Done        = 1'b0;
        Illegal     = 1'b0;
        case (state)
            S_FETCH: begin
                // Writes are masked while reset is held so MemReady cannot leak through.
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady & rst_n;
                PCWrite = MemReady & rst_n;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                Illegal = illegal_op & rst_n;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_LW_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
                Done     = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                Done     = MemReady;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUCtrl = func_alu;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
                Done     = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUCtrl     = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSrc       = 2'b01;
                Done        = 1'b1;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUCtrl = (Opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_I_WB: begin
                RegWrite = 1'b1;
                Done     = 1'b1;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
                Done    = 1'b1;
            end
            S_JAL: begin
                PCWrite  = 1'b1;
                PCSrc    = 2'b10;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                Done     = 1'b1;
            end
            S_JR: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b11;
                Done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign State = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - table-driven bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Opcode, Func;
    logic       Zero, MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSrc;
    logic [2:0] ALUCtrl;
    logic [3:0] State;
    logic       Done, Illegal;

    int compared   = 0;
    int mismatched = 0;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Func(Func), .Zero(Zero),
        .MemReady(MemReady), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUCtrl(ALUCtrl), .State(State),
        .Done(Done), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  func;
        logic        mr;
        logic [3:0]  st;
        logic [20:0] ctl;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [20:0] cv(input logic pcw, pcwc, iord, mrd, mw, irw, rw, srca,
                                       input logic [1:0] rdst, m2r, srcb, pcsrc,
                                       input logic [2:0] aluc, input logic done, ill);
        return {pcw, pcwc, iord, mrd, mw, irw, rw, srca, rdst, m2r, srcb, pcsrc, aluc, done, ill};
    endfunction

    function automatic logic [20:0] actual();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA,
                RegDst, MemtoReg, ALUSrcB, PCSrc, ALUCtrl, Done, Illegal};
    endfunction

    task automatic add(input logic [5:0] op, func, input logic mr, input logic [3:0] st,
                       input logic [20:0] ctl);
        vec_t v;
        v.op = op; v.func = func; v.mr = mr; v.st = st; v.ctl = ctl;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [24:0] act, exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got state/ctl %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        Opcode = v.op; Func = v.func; MemReady = v.mr; Zero = 1'($urandom_range(0, 1));
        #1;
        check($sformatf("vec%0d", idx), {State, actual()}, {v.st, v.ctl});
        @(posedge clk); #1;
    endtask

    logic [20:0] f1, f0, dec, deci, rwb, maddr, mrd, lwwb, mwr0, mwr1, br, iwb, jmp, jal, jr;

    initial begin
        f1    = cv(1,0,0,1,0,1,0,0, 2'd0,2'd0,2'd1,2'd0, 3'd0,0,0);
        f0    = cv(0,0,0,1,0,0,0,0, 2'd0,2'd0,2'd1,2'd0, 3'd0,0,0);
        dec   = cv(0,0,0,0,0,0,0,0, 2'd0,2'd0,2'd3,2'd0, 3'd0,0,0);
        deci  = cv(0,0,0,0,0,0,0,0, 2'd0,2'd0,2'd3,2'd0, 3'd0,0,1);
        rwb   = cv(0,0,0,0,0,0,1,0, 2'd1,2'd0,2'd0,2'd0, 3'd0,1,0);
        maddr = cv(0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd2,2'd0, 3'd0,0,0);
        mrd   = cv(0,0,1,1,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 3'd0,0,0);
        lwwb  = cv(0,0,0,0,0,0,1,0, 2'd0,2'd1,2'd0,2'd0, 3'd0,1,0);
        mwr0  = cv(0,0,1,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 3'd0,0,0);
        mwr1  = cv(0,0,1,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 3'd0,1,0);
        br    = cv(0,1,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd1, 3'd1,1,0);
        iwb   = cv(0,0,0,0,0,0,1,0, 2'd0,2'd0,2'd0,2'd0, 3'd0,1,0);
        jmp   = cv(1,0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd2, 3'd0,1,0);
        jal   = cv(1,0,0,0,0,0,1,0, 2'd2,2'd2,2'd0,2'd2, 3'd0,1,0);
        jr    = cv(1,0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd3, 3'd0,1,0);

        // add, with one FETCH wait cycle first
        add(6'h00, 6'h20, 0, 4'd0, f0);
        add(6'h00, 6'h20, 1, 4'd0, f1);
        add(6'h00, 6'h20, 1, 4'd1, dec);
        add(6'h00, 6'h20, 1, 4'd6, cv(0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 3'd0,0,0));
        add(6'h00, 6'h20, 1, 4'd7, rwb);
        // sub, and, or, slt through R_EXEC
        add(6'h00, 6'h22, 1, 4'd0, f1);
        add(6'h00, 6'h22, 1, 4'd1, dec);
        add(6'h00, 6'h22, 1, 4'd6, cv(0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 3'd1,0,0));
        add(6'h00, 6'h22, 1, 4'd7, rwb);
        add(6'h00, 6'h24, 1, 4'd0, f1);
        add(6'h00, 6'h24, 1, 4'd1, dec);
        add(6'h00, 6'h24, 1, 4'd6, cv(0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 3'd2,0,0));
        add(6'h00, 6'h24, 1, 4'd7, rwb);
        add(6'h00, 6'h25, 1, 4'd0, f1);
        add(6'h00, 6'h25, 1, 4'd1, dec);
        add(6'h00, 6'h25, 1, 4'd6, cv(0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 3'd3,0,0));
        add(6'h00, 6'h25, 1, 4'd7, rwb);
        add(6'h00, 6'h2a, 1, 4'd0, f1);
        add(6'h00, 6'h2a, 1, 4'd1, dec);
        add(6'h00, 6'h2a, 1, 4'd6, cv(0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 3'd4,0,0));
        add(6'h00, 6'h2a, 1, 4'd7, rwb);
        // lw with three MEM_RD wait cycles
        add(6'h23, 6'h00, 1, 4'd0, f1);
        add(6'h23, 6'h00, 1, 4'd1, dec);
        add(6'h23, 6'h00, 1, 4'd2, maddr);
        add(6'h23, 6'h00, 0, 4'd3, mrd);
        add(6'h23, 6'h00, 0, 4'd3, mrd);
        add(6'h23, 6'h00, 0, 4'd3, mrd);
        add(6'h23, 6'h00, 1, 4'd3, mrd);
        add(6'h23, 6'h00, 1, 4'd4, lwwb);
        // sw with one wait
        add(6'h2b, 6'h00, 1, 4'd0, f1);
        add(6'h2b, 6'h00, 1, 4'd1, dec);
        add(6'h2b, 6'h00, 1, 4'd2, maddr);
        add(6'h2b, 6'h00, 0, 4'd5, mwr0);
        add(6'h2b, 6'h00, 1, 4'd5, mwr1);
        // beq
        add(6'h04, 6'h00, 1, 4'd0, f1);
        add(6'h04, 6'h00, 1, 4'd1, dec);
        add(6'h04, 6'h00, 1, 4'd8, br);
        // addi, slti
        add(6'h08, 6'h00, 1, 4'd0, f1);
        add(6'h08, 6'h00, 1, 4'd1, dec);
        add(6'h08, 6'h00, 1, 4'd9, cv(0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd2,2'd0, 3'd0,0,0));
        add(6'h08, 6'h00, 1, 4'd10, iwb);
        add(6'h0a, 6'h00, 1, 4'd0, f1);
        add(6'h0a, 6'h00, 1, 4'd1, dec);
        add(6'h0a, 6'h00, 1, 4'd9, cv(0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd2,2'd0, 3'd4,0,0));
        add(6'h0a, 6'h00, 1, 4'd10, iwb);
        // j, jal, jr
        add(6'h02, 6'h00, 1, 4'd0, f1);
        add(6'h02, 6'h00, 1, 4'd1, dec);
        add(6'h02, 6'h00, 1, 4'd11, jmp);
        add(6'h03, 6'h00, 1, 4'd0, f1);
        add(6'h03, 6'h00, 1, 4'd1, dec);
        add(6'h03, 6'h00, 1, 4'd12, jal);
        add(6'h00, 6'h08, 1, 4'd0, f1);
        add(6'h00, 6'h08, 1, 4'd1, dec);
        add(6'h00, 6'h08, 1, 4'd13, jr);
        // illegal opcode and illegal R-type func
        add(6'h3f, 6'h00, 1, 4'd0, f1);
        add(6'h3f, 6'h00, 1, 4'd1, deci);
        add(6'h00, 6'h3f, 1, 4'd0, f1);
        add(6'h00, 6'h3f, 1, 4'd1, deci);
        add(6'h00, 6'h3f, 0, 4'd0, f0);
    end

    initial begin
        rst_n = 1'b0; Opcode = 6'h00; Func = 6'h00; Zero = 1'b0; MemReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", {State, actual()}, {4'd0, cv(0,0,0,1,0,0,0,0, 2'd0,2'd0,2'd1,2'd0, 3'd0,0,0)});
        MemReady = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) apply(vecs[i], i);

        // sw into MEM_WR wait, then asynchronous reset mid-cycle
        Opcode = 6'h2b; Func = 6'h00; MemReady = 1'b1; #1;
        check("sw_fetch", {State, actual()}, {4'd0, f1});
        @(posedge clk); #1;
        check("sw_decode", {28'd0, State}, {28'd0, 4'd1});
        @(posedge clk); #1;
        MemReady = 1'b0; @(posedge clk); #1;
        check("sw_wait", {State, actual()}, {4'd5, mwr0});
        #2;
        MemReady = 1'b1;
        rst_n = 1'b0;
        #1;
        check("async_reset_state", {21'd0, State}, {21'd0, 4'd0});
        check("async_reset_writes", {20'd0, MemWrite, IRWrite, PCWrite, Done, Illegal}, 25'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_release_fetch", {State, actual()}, {4'd0, f1});
        @(posedge clk); #1;
        check("post_release_decode", {State, actual()}, {4'd1, dec});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1);
    end

endmodule
